// File: rtl/inst_fetcher_pkg.sv
// Shared types for the instruction fetcher: word/address/byte types,
// fetch FSM encodings and the queued {pc, inst} entry.
package inst_fetcher_pkg;

    typedef logic [31:0] INS_TYPE;
    typedef logic [31:0] ADDR_TYPE;
    typedef logic [7:0]  BYTE_TYPE;

    localparam INS_TYPE ZERO_WORD = 32'h0;
    localparam logic    TRUE      = 1'b1;
    localparam logic    FALSE     = 1'b0;

    typedef enum logic {
        ISSUE = 1'b0,
        DRAIN = 1'b1
    } FETCH_STATE_TYPE;

    typedef struct packed {
        ADDR_TYPE pc;
        INS_TYPE  inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular FIFO of fetched {pc, inst} entries; clear wins over push and pop.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         clear,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output fetch_entry_t                 head
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(QUEUE_DEPTH);

    fetch_entry_t     entries [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = entries[head_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (en) begin
            if (clear) begin
                head_ptr <= '0;
                tail_ptr <= '0;
                count    <= '0;
            end else begin
                if (do_push) tail_ptr <= tail_ptr + PTR_ONE;
                if (do_pop)  head_ptr <= head_ptr + PTR_ONE;
                case ({do_push, do_pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage is data only; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (en && do_push && !clear) entries[tail_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetcher.sv
// Byte-wise instruction fetcher: issues four byte reads per instruction,
// assembles little-endian words and queues them with their PC for decode.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int       QUEUE_DEPTH = 4,
    parameter ADDR_TYPE RESET_PC    = 32'h0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rdy,
    output logic     mem_rd_en,
    output ADDR_TYPE mem_addr,
    input  logic     mem_stall,
    input  logic     mem_din_valid,
    input  BYTE_TYPE mem_din,
    output logic     inst_valid,
    output INS_TYPE  inst,
    output ADDR_TYPE inst_pc,
    input  logic     inst_ready,
    input  logic     flush,
    input  ADDR_TYPE flush_pc
);

    FETCH_STATE_TYPE state, state_next;
    ADDR_TYPE        pc, pc_next;
    logic [2:0]      issue_cnt, issue_cnt_next;
    logic [2:0]      rcv_cnt, rcv_cnt_next;
    logic [2:0]      outstanding, outstanding_next;
    logic [23:0]     asm_buf, asm_buf_next;

    logic            q_push, q_pop, q_clear, q_full, q_empty;
    logic [$clog2(QUEUE_DEPTH):0] q_count_unused;
    fetch_entry_t    q_head, q_push_data;

    logic            issue_ok, accept, resp;

    // A new instruction starts only with a free slot; once started it always completes.
    assign issue_ok  = (state == ISSUE) && (issue_cnt != 3'd4) && ((issue_cnt != 3'd0) || !q_full);
    assign mem_rd_en = rst_n && rdy && !flush && issue_ok;
    assign mem_addr  = rst_n ? (pc + {29'b0, issue_cnt}) : ZERO_WORD;
    assign accept    = mem_rd_en && !mem_stall;
    assign resp      = rdy && mem_din_valid;

    assign inst_valid = !q_empty;
    assign inst       = inst_valid ? q_head.inst : ZERO_WORD;
    assign inst_pc    = inst_valid ? q_head.pc   : ZERO_WORD;
    assign q_pop      = rdy && inst_valid && inst_ready;

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        issue_cnt_next   = issue_cnt;
        rcv_cnt_next     = rcv_cnt;
        asm_buf_next     = asm_buf;
        outstanding_next = outstanding + {2'b0, accept} - {2'b0, resp};
        q_push           = FALSE;
        q_clear          = FALSE;
        q_push_data      = '{pc: pc, inst: {mem_din, asm_buf}};

        if (rdy) begin
            if (accept) issue_cnt_next = issue_cnt + 3'd1;

            if (state == ISSUE && resp) begin
                if (rcv_cnt == 3'd3) begin
                    q_push         = TRUE;
                    pc_next        = pc + 32'd4;
                    issue_cnt_next = 3'd0;
                    rcv_cnt_next   = 3'd0;
                end else begin
                    case (rcv_cnt[1:0])
                        2'd0:    asm_buf_next[7:0]   = mem_din;
                        2'd1:    asm_buf_next[15:8]  = mem_din;
                        default: asm_buf_next[23:16] = mem_din;
                    endcase
                    rcv_cnt_next = rcv_cnt + 3'd1;
                end
            end

            if (state == DRAIN && outstanding_next == 3'd0) state_next = ISSUE;

            // Redirect discards everything; bytes still in flight are dropped in DRAIN.
            if (flush) begin
                q_push         = FALSE;
                q_clear        = TRUE;
                pc_next        = flush_pc;
                issue_cnt_next = 3'd0;
                rcv_cnt_next   = 3'd0;
                state_next     = (outstanding_next != 3'd0) ? DRAIN : ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ISSUE;
            pc          <= RESET_PC;
            issue_cnt   <= 3'd0;
            rcv_cnt     <= 3'd0;
            outstanding <= 3'd0;
        end else if (rdy) begin
            state       <= state_next;
            pc          <= pc_next;
            issue_cnt   <= issue_cnt_next;
            rcv_cnt     <= rcv_cnt_next;
            outstanding <= outstanding_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) asm_buf <= asm_buf_next;
    end

    inst_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (rdy),
        .clear     (q_clear),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count_unused),
        .head      (q_head)
    );

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a byte memory model of configurable latency.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_stall = 1'b0;
    logic        mem_din_valid = 1'b0;
    logic [7:0]  mem_din = 8'h0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;

    inst_fetcher #(
        .QUEUE_DEPTH(4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_stall    (mem_stall),
        .mem_din_valid(mem_din_valid),
        .mem_din      (mem_din),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready),
        .flush        (flush),
        .flush_pc     (flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        int         due;
    } resp_t;

    logic [7:0] mem_bytes [0:1023];
    resp_t      pend[$];
    resp_t      r_tmp;
    vec_t       got[$];
    vec_t       v_tmp;
    int         cyc = 0;
    int         lat = 1;
    int         accepted = 0;
    int         checks = 0;
    int         failures = 0;

    vec_t t_boot [4];
    vec_t t_full [5];
    vec_t t_flush[2];
    vec_t t_wrap [5];

    // Memory controller model: in-order responses, lat cycles after acceptance.
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            mem_din_valid <= 1'b0;
        end else if (rdy) begin
            if (mem_rd_en && !mem_stall) begin
                r_tmp.data = mem_bytes[mem_addr[9:0]];
                r_tmp.due  = cyc + lat;
                pend.push_back(r_tmp);
                accepted++;
            end
            cyc++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_din_valid <= 1'b1;
                mem_din       <= pend[0].data;
                void'(pend.pop_front());
            end else begin
                mem_din_valid <= 1'b0;
            end
        end
        if (rst_n && rdy && inst_valid && inst_ready) begin
            v_tmp.pc   = inst_pc;
            v_tmp.inst = inst;
            got.push_back(v_tmp);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cmp_got(input int idx, input vec_t e, input string name);
        if (idx < got.size()) begin
            chk({name, "_pc"}, got[idx].pc, e.pc);
            chk({name, "_inst"}, got[idx].inst, e.inst);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s: entry missing, got %0d entries required %0d", name, got.size(), idx + 1);
        end
    endtask

    task automatic wait_got(input int n);
        for (int k = 0; k < 300 && got.size() < n; k++) @(negedge clk);
    endtask

    task automatic do_reset(input logic ready, input int latency);
        rst_n      = 1'b0;
        flush      = 1'b0;
        mem_stall  = 1'b0;
        rdy        = 1'b1;
        inst_ready = ready;
        repeat (2) @(negedge clk);
        got.delete();
        accepted = 0;
        lat      = latency;
        rst_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first;

        for (int i = 0; i < 1024; i++) mem_bytes[i] = 8'(i);
        mem_bytes[0] = 8'h13; mem_bytes[1] = 8'h05; mem_bytes[2] = 8'h10; mem_bytes[3] = 8'h00;
        mem_bytes[4] = 8'h93; mem_bytes[5] = 8'h05; mem_bytes[6] = 8'h20; mem_bytes[7] = 8'h00;

        t_boot  = '{'{32'h0, 32'h00100513}, '{32'h4, 32'h00200593},
                    '{32'h8, 32'h0B0A0908}, '{32'hC, 32'h0F0E0D0C}};
        t_full  = '{'{32'h0, 32'h00100513}, '{32'h4, 32'h00200593}, '{32'h8, 32'h0B0A0908},
                    '{32'hC, 32'h0F0E0D0C}, '{32'h10, 32'h13121110}};
        t_flush = '{'{32'h100, 32'h03020100}, '{32'h104, 32'h07060504}};
        t_wrap  = '{'{32'h4, 32'h00200593}, '{32'h8, 32'h0B0A0908}, '{32'hC, 32'h0F0E0D0C},
                    '{32'h10, 32'h13121110}, '{32'h14, 32'h17161514}};

        // Reset state
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);

        // Boot fetch, latency and in-order delivery
        do_reset(1'b1, 1);
        #1;
        chk("boot_first_addr", mem_addr, 0);
        chk("boot_first_rd_en", mem_rd_en, 1);
        first = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (inst_valid && first == 0) first = k;
        end
        chk("boot_first_valid_in_range", 32'(first >= 5 && first <= 6), 1);
        wait_got(4);
        for (int i = 0; i < 4; i++) cmp_got(i, t_boot[i], $sformatf("boot_%0d", i));

        // Queue fills with consumer stalled, then drains and fetching resumes
        do_reset(1'b0, 1);
        repeat (40) @(negedge clk);
        chk("full_accepted", accepted, 16);
        chk("full_rd_en", mem_rd_en, 0);
        chk("full_head_valid", inst_valid, 1);
        chk("full_head_pc", inst_pc, 0);
        inst_ready = 1'b1;
        wait_got(5);
        for (int i = 0; i < 5; i++) cmp_got(i, t_full[i], $sformatf("full_%0d", i));

        // Stall after two bytes accepted
        do_reset(1'b1, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall_addr_%0d", k), mem_addr, 32'h2);
            chk($sformatf("stall_rd_en_%0d", k), mem_rd_en, 1);
            @(negedge clk);
        end
        mem_stall = 1'b0;
        wait_got(1);
        cmp_got(0, t_boot[0], "stall_word");

        // Flush with three reads outstanding
        do_reset(1'b1, 4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("flush_pre_accepted", accepted, 3);
        flush    = 1'b1;
        flush_pc = 32'h100;
        #1;
        chk("flush_cycle_rd_en", mem_rd_en, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_inst_valid", inst_valid, 0);
        chk("flush_drain_rd_en", mem_rd_en, 0);
        for (int k = 0; k < 30 && !mem_rd_en; k++) @(negedge clk);
        chk("flush_resume_rd_en", mem_rd_en, 1);
        chk("flush_resume_addr", mem_addr, 32'h100);
        chk("flush_drain_no_requests", accepted, 3);
        wait_got(2);
        for (int i = 0; i < 2; i++) cmp_got(i, t_flush[i], $sformatf("flush_%0d", i));

        // Push and pop together at full-minus-one, then wrap the pointers
        do_reset(1'b0, 1);
        repeat (19) @(posedge clk);
        @(negedge clk);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        #1;
        chk("pp_pop_count", got.size(), 1);
        chk("pp_rd_en_after", mem_rd_en, 1);
        chk("pp_head_pc", inst_pc, 32'h4);
        got.delete();
        repeat (20) @(negedge clk);
        chk("pp_full_rd_en", mem_rd_en, 0);
        chk("pp_accepted", accepted, 20);
        inst_ready = 1'b1;
        wait_got(5);
        for (int i = 0; i < 5; i++) cmp_got(i, t_wrap[i], $sformatf("wrap_%0d", i));

        // rdy=0 freeze, then asynchronous reset mid-instruction
        do_reset(1'b0, 1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold_rd_en_%0d", k), mem_rd_en, 0);
            chk($sformatf("hold_addr_%0d", k), mem_addr, 32'hA);
            @(negedge clk);
        end
        rdy = 1'b1;
        @(posedge clk);
        #3;
        chk("pre_areset_valid", inst_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("areset_inst_valid", inst_valid, 0);
        chk("areset_inst", inst, 0);
        chk("areset_inst_pc", inst_pc, 0);
        chk("areset_mem_rd_en", mem_rd_en, 0);
        chk("areset_mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        got.delete();
        inst_ready = 1'b1;
        rst_n      = 1'b1;
        #1;
        chk("areset_restart_addr", mem_addr, 0);
        wait_got(1);
        cmp_got(0, t_boot[0], "areset_first");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Producer side of the decode interface. Reads instruction bytes from the byte-wide memory controller port and assembles little-endian 32-bit instructions.
- Buffers each instruction with its PC in a small queue and presents the queue head to the decoder/dispatch stage with a valid/ready handshake.
- Redirects to a new PC on flush (branch mispredict or jalr resolve), discarding queued and in-flight data.

Parameters:
- QUEUE_DEPTH, 4, number of {pc, inst} entries; power of two, at least 2.
- RESET_PC, 32'h0, PC fetched after reset.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0, all state holds.
- mem_rd_en  out  1  byte read request.
- mem_addr  out  32  byte address of the request.
- mem_stall  in  1  controller cannot accept a request this cycle.
- mem_din_valid  in  1  returned byte valid.
- mem_din  in  8  returned byte; responses come back in request order.
- inst_valid  out  1  queue head valid.
- inst  out  32  queue head instruction (INS_TYPE).
- inst_pc  out  32  queue head PC.
- inst_ready  in  1  consumer takes the head this cycle.
- flush  in  1  redirect request.
- flush_pc  in  32  new fetch PC.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; queue empty; state=ISSUE.
  - Byte counters 0; outstanding=0.
  - All outputs 0.
- Request acceptance: a request is accepted in a cycle where mem_rd_en=1 && mem_stall=0 && rdy=1.
  - mem_addr=pc+issue_cnt.
  - Each acceptance increments issue_cnt (0..4) and outstanding.
- Issue gating: in ISSUE, a new instruction is started only when the queue is not full, counting the slot reserved for the instruction in progress.
  - Requests for the 4 bytes may be issued on back-to-back cycles.
  - mem_rd_en=0 once issue_cnt=4.
- Response handling:
  - Each mem_din_valid decrements outstanding.
  - The byte is written to buf[8*rcv_cnt +: 8] and rcv_cnt increments.
- Instruction completion: when rcv_cnt reaches 4 (on the cycle the 4th byte arrives):
  - push {pc, assembled word} into the queue;
  - pc+=4; issue_cnt=rcv_cnt=0;
  - the next instruction may begin issuing on the following cycle.
- Minimum latency: 4 issue cycles plus 1 response cycle. The first inst_valid after reset appears no earlier than cycle 6, given a controller with 1-cycle response and no stalls.
- Consumer handshake:
  - inst/inst_pc/inst_valid come from registered queue head state, not combinationally from mem_din.
  - A pop occurs when inst_valid && inst_ready.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - A push is never dropped: issue gating guarantees a free slot.
- Queue wrap-around: head and tail pointers wrap modulo QUEUE_DEPTH. Full = count==QUEUE_DEPTH. Empty = count==0.
- Flush (rdy=1), taking priority over push/pop the same cycle:
  - queue cleared; inst_valid=0 next cycle;
  - pc=flush_pc; issue_cnt=rcv_cnt=0.
  - If outstanding (after this cycle's response) is >0, go to DRAIN; otherwise go to ISSUE.
- DRAIN state:
  - mem_rd_en=0.
  - Each mem_din_valid is discarded and decrements outstanding.
  - At 0, go to ISSUE.
  - A second flush during DRAIN updates pc only.
- rdy=0:
  - No state change; mem_rd_en=0.
  - The controller is also gated by rdy, so no responses arrive.
- States: ISSUE (issuing/collecting) and DRAIN (discarding stale responses).
- Widths: pc and addresses are 32-bit and wrap mod 2^32. outstanding is 3 bits and never exceeds 4.
- Misaligned flush_pc is accepted as given.

Decomposition:
- Shared defines header, extended with:
  - INS_TYPE, ADDR_TYPE, ZERO_WORD, TRUE/FALSE (existing);
  - FETCH_STATE_TYPE and the ISSUE/DRAIN encodings;
  - BYTE_TYPE.
- One sub-module, inst_queue: circular FIFO of {pc, inst}, parameterised by QUEUE_DEPTH.
  - push, pop and clear inputs; full, empty and count outputs; head data output.
  - clear has priority over push and pop.

Test Plan:
- Reset with RESET_PC=0, memory bytes 0x00..0x07 = 13 05 10 00 93 05 20 00, inst_ready=1, no stalls -> inst=0x00100513 @pc 0, then 0x00200593 @pc 4, in order.
- inst_ready=0, QUEUE_DEPTH=4 -> exactly 4 entries queued; mem_rd_en stays 0 afterwards. Raise inst_ready -> pcs 0, 4, 8, 12 delivered, then fetching resumes at pc 16.
- mem_stall=1 held for 5 cycles mid-instruction (after 2 bytes accepted) -> mem_addr is held at pc+2 and the assembled word is still correct.
- flush with flush_pc=0x100 while 3 reads are outstanding -> the 3 stale bytes are discarded, no stale instruction is emitted, and the first inst_pc after the flush is 0x100.
- Simultaneous push and pop with the queue full-minus-one, followed by a pointer wrap -> count constant, order preserved across the wrap.
- rst_n asserted mid-instruction, asynchronously between clock edges -> outputs 0 immediately; after release, fetching restarts at RESET_PC.
